// File: rtl/bw_meter_pkg.sv
// bw_meter_pkg -- shared definitions for the bandwidth meter.
//   Holds the FSM state encoding and the default values for the
//   counter/result width and the bytes-per-beat shift.
package bw_meter_pkg;

    localparam int BW_WIDTH_DEFAULT      = 32;
    localparam int BW_BEAT_SHIFT_DEFAULT = 3;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_MEASURE = 3'd1,
        ST_LOAD    = 3'd2,
        ST_DIVIDE  = 3'd3,
        ST_DONE    = 3'd4
    } bw_state_t;

endpackage

// File: rtl/bw_window_counter.sv
// bw_window_counter -- measurement window timer.
//   Down-counter loaded with the window length when a window starts;
//   decrements while the window runs and flags the final window cycle
//   with a terminal-count compare.
// Ports:
//   clk, rstn  clock, asynchronous active-low reset
//   load       load len into the counter (window start edge)
//   len        window length in cycles (non-zero when loaded)
//   run        window in progress
//   last       high during the final cycle of the window
module bw_window_counter
    import bw_meter_pkg::*;
#(
    parameter int WIDTH = BW_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             load,
    input  logic [WIDTH-1:0] len,
    input  logic             run,
    output logic             last
);

    logic [WIDTH-1:0] remain;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            remain <= '0;
        end else if (load) begin
            remain <= len;
        end else if (run && (remain != '0)) begin
            remain <= remain - 1'b1;
        end
    end

    // remain equals len in the first window cycle, so it reaches 1 in the last
    assign last = run && (remain == WIDTH'(1));

endmodule

// File: rtl/bw_meter.sv
// bw_meter -- AXI data-beat bandwidth meter.
//   Counts completed beats over a programmable window, then drives an
//   external divider with (beats << BEAT_SHIFT) / window and captures
//   the quotient as bytes per cycle.
// Ports:
//   clk, rstn        clock, asynchronous active-low reset
//   en               measurement enable
//   window_cycles    window length in cycles (0 keeps the block idle)
//   beat             one data beat completed this cycle
//   div_start        divider control: 0 = load operands, 1 = iterate/hold
//   div_n, div_d     dividend / divisor to the external divider
//   div_q, div_r     quotient / remainder from the external divider
//   result           bytes per cycle from the last completed window
//   result_valid     one-cycle pulse when result is updated
//   busy             block is not idle
//   overflow         sticky: beat counter saturated
// Build option:
//   BW_METER_ROUND_EN  round the quotient to nearest instead of truncating
//
// state    | meaning
// ---------+-------------------------------------------------------
// IDLE     | waiting for en with a non-zero window
// MEASURE  | counting beats, lasts window_cycles cycles
// LOAD     | divider loads operands (div_start=0)
// DIVIDE   | divider iterates, WIDTH+1 cycles
// DONE     | result_valid pulse; restart or return to idle
module bw_meter
    import bw_meter_pkg::*;
#(
    parameter int WIDTH      = BW_WIDTH_DEFAULT,
    parameter int BEAT_SHIFT = BW_BEAT_SHIFT_DEFAULT
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic [WIDTH-1:0] window_cycles,
    input  logic             beat,
    output logic             div_start,
    output logic [WIDTH-1:0] div_n,
    output logic [WIDTH-1:0] div_d,
    input  logic [WIDTH-1:0] div_q,
    input  logic [WIDTH-1:0] div_r,
    output logic [WIDTH-1:0] result,
    output logic             result_valid,
    output logic             busy,
    output logic             overflow
);

    localparam int CW  = WIDTH - BEAT_SHIFT;
    localparam int DCW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] BEAT_MAX = '1;

    bw_state_t        state;
    logic [CW-1:0]    beat_cnt;
    logic [CW-1:0]    beat_nxt;
    logic [WIDTH-1:0] window_q;
    logic [DCW-1:0]   div_cnt;
    logic [WIDTH-1:0] capture;
    logic             start_ok;
    logic             win_load;
    logic             win_run;
    logic             win_last;

    assign start_ok = en && (window_cycles != '0);
    assign win_load = start_ok && ((state == ST_IDLE) || (state == ST_DONE));
    assign win_run  = (state == ST_MEASURE);

    bw_window_counter #(
        .WIDTH (WIDTH)
    ) u_window (
        .clk  (clk),
        .rstn (rstn),
        .load (win_load),
        .len  (window_cycles),
        .run  (win_run),
        .last (win_last)
    );

    always_comb begin
        beat_nxt = beat_cnt;
        if (beat && (beat_cnt != BEAT_MAX)) begin
            beat_nxt = beat_cnt + 1'b1;
        end
    end

`ifdef BW_METER_ROUND_EN
    logic [WIDTH:0] rem_x2;
    logic           round_up;

    assign rem_x2   = {div_r, 1'b0};
    assign round_up = (rem_x2 >= {1'b0, div_d}) && (div_q != '1);
    assign capture  = round_up ? (div_q + 1'b1) : div_q;
`else
    logic div_r_unused;

    assign div_r_unused = ^div_r;
    assign capture      = div_q;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= ST_IDLE;
            beat_cnt     <= '0;
            window_q     <= '0;
            div_cnt      <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            busy         <= 1'b0;
            overflow     <= 1'b0;
            div_start    <= 1'b0;
            div_n        <= '0;
            div_d        <= '0;
        end else begin
            result_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_ok) begin
                        state    <= ST_MEASURE;
                        busy     <= 1'b1;
                        beat_cnt <= '0;
                        window_q <= window_cycles;
                    end
                end
                ST_MEASURE: begin
                    if (!en) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        beat_cnt <= beat_nxt;
                        if (beat && (beat_cnt == BEAT_MAX - 1'b1)) begin
                            overflow <= 1'b1;
                        end
                        // beat_nxt already includes a beat in the final cycle
                        if (win_last) begin
                            state <= ST_LOAD;
                            div_n <= {beat_nxt, {BEAT_SHIFT{1'b0}}};
                            div_d <= window_q;
                        end
                    end
                end
                ST_LOAD: begin
                    state     <= ST_DIVIDE;
                    div_start <= 1'b1;
                    div_cnt   <= DCW'(WIDTH);
                end
                ST_DIVIDE: begin
                    if (div_cnt == '0) begin
                        state        <= ST_DONE;
                        result       <= capture;
                        result_valid <= 1'b1;
                    end else begin
                        div_cnt <= div_cnt - 1'b1;
                    end
                end
                ST_DONE: begin
                    div_start <= 1'b0;
                    if (start_ok) begin
                        state    <= ST_MEASURE;
                        beat_cnt <= '0;
                        window_q <= window_cycles;
                    end else begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    busy      <= 1'b0;
                    div_start <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bw_meter.sv
// tb_bw_meter -- self-checking bench for bw_meter.
//   Two instances: WIDTH=32 with an iterative restoring divider, and
//   WIDTH=8 with a single-cycle divider for the saturation case.
//   Expected results come from plain arithmetic on the beat count.
//   Honors BW_METER_ROUND_EN for the expected rounding.
module tb_bw_meter;

    localparam int W  = 32;
    localparam int W8 = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rstn;
    logic          en, beat;
    logic [W-1:0]  window_cycles;
    logic          div_start;
    logic [W-1:0]  div_n, div_d, div_q, div_r, result;
    logic          result_valid, busy, overflow;

    logic          en8, beat8;
    logic [W8-1:0] window8;
    logic          div_start8;
    logic [W8-1:0] div_n8, div_d8, div_q8, div_r8, result8;
    logic          result_valid8, busy8, overflow8;

    int n_err = 0;
    int n_chk = 0;
    longint prev_result = 0;

    bw_meter #(.WIDTH(W), .BEAT_SHIFT(3)) u_dut (
        .clk(clk), .rstn(rstn), .en(en), .window_cycles(window_cycles), .beat(beat),
        .div_start(div_start), .div_n(div_n), .div_d(div_d), .div_q(div_q), .div_r(div_r),
        .result(result), .result_valid(result_valid), .busy(busy), .overflow(overflow)
    );

    bw_meter #(.WIDTH(W8), .BEAT_SHIFT(3)) u_dut8 (
        .clk(clk), .rstn(rstn), .en(en8), .window_cycles(window8), .beat(beat8),
        .div_start(div_start8), .div_n(div_n8), .div_d(div_d8), .div_q(div_q8), .div_r(div_r8),
        .result(result8), .result_valid(result_valid8), .busy(busy8), .overflow(overflow8)
    );

    // restoring divider: loads while div_start=0, then W iterations and hold
    logic [W:0]   dv_rem;
    logic [W-1:0] dv_quo, dv_den;
    int           dv_cnt;

    always @(posedge clk) begin
        logic [W:0] tmp;
        if (!div_start) begin
            dv_rem <= '0;
            dv_quo <= div_n;
            dv_den <= div_d;
            dv_cnt <= 0;
        end else if (dv_cnt < W) begin
            tmp = {dv_rem[W-1:0], dv_quo[W-1]};
            if (tmp >= {1'b0, dv_den}) begin
                dv_rem <= tmp - {1'b0, dv_den};
                dv_quo <= {dv_quo[W-2:0], 1'b1};
            end else begin
                dv_rem <= tmp;
                dv_quo <= {dv_quo[W-2:0], 1'b0};
            end
            dv_cnt <= dv_cnt + 1;
        end
    end
    assign div_q = dv_quo;
    assign div_r = dv_rem[W-1:0];

    always_comb begin
        div_q8 = '1;
        div_r8 = div_n8;
        if (div_d8 != '0) begin
            div_q8 = div_n8 / div_d8;
            div_r8 = div_n8 % div_d8;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint exp_count(longint beats, int width, int shift);
        longint maxc = (64'sd1 <<< (width - shift)) - 1;
        return (beats > maxc) ? maxc : beats;
    endfunction

    function automatic longint exp_result(longint beats, longint win, int width, int shift);
        longint n = exp_count(beats, width, shift) * (64'sd1 <<< shift);
        longint q = n / win;
        longint r = n % win;
`ifdef BW_METER_ROUND_EN
        if ((2 * r >= win) && (q != ((64'sd1 <<< width) - 1))) q = q + 1;
`else
        if (r < 0) q = q - 1;
`endif
        return q;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // the beat offered in the cycle before MEASURE must be ignored
    task automatic begin_window(input int w);
        window_cycles = W'(w);
        en = 1'b1;
        beat = 1'b1;
        step();
        chk("enter_busy", busy, 1);
        chk("enter_start", div_start, 0);
    endtask

    task automatic measure_window(input int w, input logic [127:0] mask, input bit rnd, input bit keep_en);
        longint nb = 0;
        int k = 0;
        int bad = 0;
        logic [W-1:0] n_hold;
        longint er;
        for (int i = 1; i <= w; i++) begin
            if (rnd) beat = 1'($urandom & 1);
            else     beat = mask[i-1];
            if (beat) nb++;
            step();
        end
        chk("load_start", div_start, 0);
        chk("load_n", div_n, exp_count(nb, W, 3) * 8);
        chk("load_d", div_d, w);
        n_hold = div_n;
        beat = 1'($urandom & 1);
        en = 1'($urandom & 1);
        while (k < 60) begin
            step();
            k++;
            if (result_valid) break;
            if (div_start !== 1'b1 || div_n !== n_hold || div_d !== W'(w)) bad++;
            beat = 1'($urandom & 1);
        end
        er = exp_result(nb, w, W, 3);
        chk("latency", k, W + 2);
        chk("div_hold", bad, 0);
        chk("result", result, er);
        chk("done_start", div_start, 1);
        prev_result = er;
        en = keep_en;
        beat = 1'b0;
        step();
        chk("after_rv", result_valid, 0);
        chk("after_busy", busy, keep_en);
        chk("after_result", result, prev_result);
    endtask

    initial begin
        #600000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int bad;
        int k;
        int w;
        bit in_meas;
        bit keep;

        rstn = 1'b0; en = 1'b0; beat = 1'b0; window_cycles = '0;
        en8 = 1'b0; beat8 = 1'b0; window8 = '0;
        repeat (3) step();
        chk("rst_result", result, 0);
        chk("rst_rv", result_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_start", div_start, 0);
        chk("rst_n", div_n, 0);
        chk("rst_d", div_d, 0);
        rstn = 1'b1;
        step();

        // window=100, beat every cycle
        begin_window(100);
        measure_window(100, '1, 1'b0, 1'b0);

        // window=3, beats in cycles 1 and 3
        begin_window(3);
        measure_window(3, 128'b101, 1'b0, 1'b0);

        // window=3, a single beat
        begin_window(3);
        measure_window(3, 128'b010, 1'b0, 1'b0);

        // abort at window cycle 50 of 100
        begin_window(100);
        for (int i = 1; i < 50; i++) begin
            beat = 1'($urandom & 1);
            step();
        end
        en = 1'b0;
        beat = 1'b1;
        step();
        chk("abort_busy", busy, 0);
        chk("abort_start", div_start, 0);
        bad = 0;
        repeat (40) begin
            beat = 1'($urandom & 1);
            step();
            if (result_valid || busy) bad++;
        end
        chk("abort_no_rv", bad, 0);
        chk("abort_result", result, prev_result);
        begin_window(10);
        measure_window(10, '1, 1'b0, 1'b0);

        // zero window never starts
        window_cycles = '0;
        en = 1'b1;
        bad = 0;
        repeat (200) begin
            beat = 1'($urandom & 1);
            step();
            if (busy) bad++;
        end
        chk("zero_win_busy", bad, 0);
        en = 1'b0;
        step();

        // reset in the middle of DIVIDE
        begin_window(20);
        for (int i = 1; i <= 20; i++) begin
            beat = 1'b1;
            step();
        end
        repeat (5) step();
        #2;
        rstn = 1'b0;
        #1;
        chk("mid_rst_result", result, 0);
        chk("mid_rst_rv", result_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ovf", overflow, 0);
        chk("mid_rst_start", div_start, 0);
        chk("mid_rst_n", div_n, 0);
        chk("mid_rst_d", div_d, 0);
        en = 1'b0;
        beat = 1'b0;
        step();
        rstn = 1'b1;
        prev_result = 0;
        bad = 0;
        repeat (60) begin
            step();
            if (result_valid || busy) bad++;
        end
        chk("post_rst_quiet", bad, 0);

        // WIDTH=8 saturation
        en8 = 1'b1;
        window8 = 8'd40;
        beat8 = 1'b1;
        step();
        for (int i = 1; i <= 40; i++) begin
            beat8 = 1'b1;
            step();
        end
        chk("sat_n", div_n8, 248);
        chk("sat_d", div_d8, 40);
        chk("sat_ovf", overflow8, 1);
        en8 = 1'b0;
        k = 0;
        while (k < 30) begin
            step();
            k++;
            if (result_valid8) break;
        end
        chk("sat_latency", k, W8 + 2);
        chk("sat_result", result8, exp_result(40, 40, W8, 3));
        step();
        chk("sat_busy", busy8, 0);
        chk("sat_ovf_sticky", overflow8, 1);

        // random windows, some back-to-back
        in_meas = 1'b0;
        w = 1;
        for (int t = 0; t < 12; t++) begin
            keep = (t == 11) ? 1'b0 : 1'($urandom & 1);
            if (!in_meas) begin
                w = int'($urandom_range(1, 40));
                begin_window(w);
            end
            measure_window(w, '0, 1'b1, keep);
            in_meas = keep;
        end
        chk("ovf32_clear", overflow, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/bw_meter.md
BW_METER -- requirements
Module: bw_meter

Interface
REQ-001 The block SHALL provide parameter WIDTH, default 32, as the width of the counters, the divider operands and the result.
REQ-002 The block SHALL provide parameter BEAT_SHIFT, default 3, as log2 of the bytes per beat (8 bytes per beat by default).
REQ-003 The block SHALL provide the following ports:
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- en  in  1  measurement enable
- window_cycles  in  WIDTH  measurement window length in cycles
- beat  in  1  one AXI data beat completed this cycle (valid&ready)
- div_start  out  1  divider control (low = load operands, high = iterate/hold)
- div_n  out  WIDTH  dividend to the divider
- div_d  out  WIDTH  divisor to the divider
- div_q  in  WIDTH  divider quotient
- div_r  in  WIDTH  divider remainder
- result  out  WIDTH  bytes per cycle
- result_valid  out  1  one-cycle pulse when result is updated
- busy  out  1  state is not IDLE
- overflow  out  1  sticky flag, beat counter saturated

Function
REQ-004 The block SHALL implement a state machine with states IDLE, MEASURE, LOAD, DIVIDE and DONE.
REQ-005 IDLE->MEASURE SHALL occur when en=1 and window_cycles!=0; both counters clear on entry, and window_cycles is sampled into a holding register on entry.
REQ-006 With window_cycles=0 the block SHALL remain in IDLE with busy=0.
REQ-007 MEASURE SHALL last exactly window_cycles cycles and count beat=1 in every one of them, including the first and the last.
REQ-008 The beat counter SHALL saturate at 2^(WIDTH-BEAT_SHIFT)-1; reaching saturation SHALL set overflow, which stays set until reset.
REQ-009 MEASURE->LOAD SHALL occur after the final window cycle; LOAD lasts 1 cycle with div_start=0, div_n = beat_count<<BEAT_SHIFT, and div_d = the sampled window.
REQ-010 DIVIDE SHALL hold div_start=1 for exactly WIDTH+1 cycles; div_n and div_d SHALL be held stable throughout DIVIDE.
REQ-011 On the last DIVIDE edge the block SHALL register div_q into result; in DONE, result_valid=1 for 1 cycle.
REQ-012 result_valid SHALL be asserted exactly WIDTH+3 cycles after the final MEASURE cycle.
REQ-013 result SHALL hold its value until the next DONE.
REQ-014 From DONE, the next state SHALL be MEASURE with fresh counters if en=1, otherwise IDLE; back-to-back windows therefore have a gap of WIDTH+3 unmeasured cycles.
REQ-015 When en falls during MEASURE, the block SHALL abort to IDLE on the next edge with no result_valid and result unchanged.
REQ-016 Once LOAD is entered, en=0 SHALL NOT abort; the divide completes and the result is delivered.
REQ-017 div_start SHALL be 0 in IDLE, MEASURE and LOAD, and 1 in DIVIDE and DONE.
REQ-018 A beat that coincides with the final MEASURE cycle SHALL be counted, and beats outside MEASURE SHALL be ignored.

Reset
REQ-019 rstn=0 SHALL asynchronously force the following values: state=IDLE, counters=0, result=0, result_valid=0, overflow=0, busy=0, div_start=0, div_n=0, div_d=0.
REQ-020 Reset asserted mid-DIVIDE SHALL discard the operation, and no result_valid SHALL follow reset release.

Configuration
REQ-021 With macro BW_METER_ROUND_EN defined, the capture SHALL be result = div_q+1 when 2*div_r >= div_d (compared at WIDTH+1 bits) and div_q is not all-ones, otherwise div_q.
REQ-022 Without BW_METER_ROUND_EN, result SHALL be div_q (truncated), and div_r SHALL be unused.

Structure
REQ-023 Package bw_meter_pkg SHALL hold the state encoding (IDLE=0, MEASURE=1, LOAD=2, DIVIDE=3, DONE=4) and the defaults for WIDTH and BEAT_SHIFT.
REQ-024 The block SHALL use one sub-module, bw_window_counter, which counts window cycles and generates the last-cycle strobe.
REQ-025 The divider SHALL be external to the block and connected at the next level up.

Verification
REQ-026 The bench SHALL cover these directed scenarios (WIDTH=32, BEAT_SHIFT=3, real divider attached):
- window=100, beat every cycle -> div_n=800, div_d=100, result=8, result_valid 35 cycles after the last window cycle.
- window=3, beats in cycles 1 and 3 only -> div_n=16, result=5 in both macro builds.
- window=3, one beat -> result=2 without the macro, result=3 with BW_METER_ROUND_EN.
- en dropped at window cycle 50 of 100 -> return to IDLE, no result_valid, result keeps its prior value; en re-raised -> new window starts from zero counts.
- window=0 with en=1 -> busy stays 0 for 200 cycles.
- rstn pulsed low during DIVIDE -> all outputs 0 immediately, no pulse after release.
- BEAT_SHIFT=3, WIDTH=8, window=40, beat every cycle -> counter saturates at 31, overflow=1, div_n=248.
